// File: rtl/ucsbece154a_mem_responder_if.sv
// Request/response bundle between the multicycle core's memory port and the
// memory responder. The core drives the request side, the responder drives the response side.
interface ucsbece154a_mem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] a_i;
    logic [31:0] wd_i;
    logic [31:0] rd_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, a_i, wd_i,
        input  rd_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, a_i, wd_i,
        output rd_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/ucsbece154a_mem_responder.sv
// Word-addressed memory responder with programmable wait states: IDLE -> WAIT -> RESP,
// a one-cycle ready pulse per request and error reporting for misaligned/out-of-range addresses.
module ucsbece154a_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    ucsbece154a_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT_C   = 4'(LATENCY);
    localparam logic [31:0] DEPTH_C = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_err(input logic [31:0] addr);
        logic misaligned_v;
        logic out_of_range_v;
        misaligned_v   = (addr[1:0] != 2'b00);
        out_of_range_v = ({2'b00, addr[31:2]} >= DEPTH_C);
        return misaligned_v | out_of_range_v;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nxt_s;
    logic              accept_s;
    logic              enter_resp_s;

    logic              we_r;
    logic [31:0]       a_r;
    logic [31:0]       wd_r;

    logic              ready_r;
    logic              err_r;
    logic              busy_r;
    logic [31:0]       rd_r;

    logic              txn_we_s;
    logic [31:0]       txn_a_s;
    logic              txn_err_s;
    logic [IDX_W-1:0]  txn_idx_s;
    logic [31:0]       rd_nxt_s;
    logic              busy_nxt_s;
    logic              mem_we_s;

    logic [31:0]       mem_r [DEPTH_WORDS];

    // State and wait-counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; the counter reaching zero in WAIT moves to RESP on that same edge.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_i) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = LAT_C;
                    if (LAT_C == 4'd0) begin
                        state_nxt_s  = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_nxt_s    = 4'd0;
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_nxt_s    = cnt_r - 4'd1;
                    state_nxt_s  = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Request capture; with zero wait states RESP is entered on the accept edge,
    // so the response is computed from the live inputs in that case.
    always_comb begin
        if (state_r == ST_IDLE) begin
            txn_we_s = bus.we_i;
            txn_a_s  = bus.a_i;
        end else begin
            txn_we_s = we_r;
            txn_a_s  = a_r;
        end
        txn_err_s = addr_err(txn_a_s);
        txn_idx_s = txn_a_s[IDX_W+1:2];
    end

    // Next values for the registered response outputs.
    always_comb begin
        rd_nxt_s   = rd_r;
        busy_nxt_s = busy_r;
        if (enter_resp_s) begin
            if (txn_err_s) begin
                rd_nxt_s = 32'd0;
            end else if (!txn_we_s) begin
                rd_nxt_s = mem_r[txn_idx_s];
            end else begin
                rd_nxt_s = rd_r;
            end
        end else begin
            rd_nxt_s = rd_r;
        end
        if (accept_s) begin
            busy_nxt_s = 1'b1;
        end else if (state_r == ST_RESP) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        mem_we_s = (state_r == ST_RESP) && we_r && !err_r;
    end

    // Captured request fields, loaded only on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r <= 1'b0;
            a_r  <= 32'd0;
            wd_r <= 32'd0;
        end else if (accept_s) begin
            we_r <= bus.we_i;
            a_r  <= bus.a_i;
            wd_r <= bus.wd_i;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rd_r    <= 32'd0;
        end else begin
            ready_r <= enter_resp_s;
            err_r   <= enter_resp_s & txn_err_s;
            busy_r  <= busy_nxt_s;
            rd_r    <= rd_nxt_s;
        end
    end

    // Write commits on the edge leaving RESP, so a reset during RESP still aborts it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[a_r[IDX_W+1:2]] <= wd_r;
        end
    end

    assign bus.rd_o    = rd_r;
    assign bus.ready_o = ready_r;
    assign bus.err_o   = err_r;
    assign bus.busy_o  = busy_r;

endmodule

// File: tb/tb_ucsbece154a_mem_responder.sv
// Bench for the memory responder: three instances (LATENCY 2, 0, 15) checked against
// directed vectors, corner sequences and a random run against a word-array reference model.
module tb_ucsbece154a_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [31:0] a_v  [3];
    logic [31:0] wd_v [3];
    logic [2:0]  ready_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;
    logic [31:0] rd_v [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [3][256];
    logic [31:0] mdl_rd  [3];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        bit          scr;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    ucsbece154a_mem_responder_if bus0 ();
    ucsbece154a_mem_responder_if bus1 ();
    ucsbece154a_mem_responder_if bus2 ();

    assign bus0.req_i = req_v[0];
    assign bus0.we_i  = we_v[0];
    assign bus0.a_i   = a_v[0];
    assign bus0.wd_i  = wd_v[0];
    assign bus1.req_i = req_v[1];
    assign bus1.we_i  = we_v[1];
    assign bus1.a_i   = a_v[1];
    assign bus1.wd_i  = wd_v[1];
    assign bus2.req_i = req_v[2];
    assign bus2.we_i  = we_v[2];
    assign bus2.a_i   = a_v[2];
    assign bus2.wd_i  = wd_v[2];

    assign ready_v = {bus2.ready_o, bus1.ready_o, bus0.ready_o};
    assign err_v   = {bus2.err_o, bus1.err_o, bus0.err_o};
    assign busy_v  = {bus2.busy_o, bus1.busy_o, bus0.busy_o};
    assign rd_v[0] = bus0.rd_o;
    assign rd_v[1] = bus1.rd_o;
    assign rd_v[2] = bus2.rd_o;

    ucsbece154a_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(bus0));
    ucsbece154a_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
    ucsbece154a_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got=%h want=%h", nm, k, got, exp);
        end
    endtask

    // Reference model: word array indexed by byte address / 4; rd holds across writes.
    task automatic model(input int k, input logic w, input logic [31:0] addr, input logic [31:0] data,
                         output logic e, output logic [31:0] r);
        e = ((addr % 4) != 0) || ((addr / 4) >= 256);
        if (e) begin
            mdl_rd[k] = 32'd0;
        end else if (w) begin
            mdl_mem[k][addr / 4] = data;
        end else begin
            mdl_rd[k] = mdl_mem[k][addr / 4];
        end
        r = mdl_rd[k];
    endtask

    // Issue one request (called just after a negedge with the DUT idle), wait for ready.
    task automatic do_txn(input int k, input logic w, input logic [31:0] addr, input logic [31:0] data,
                          input bit scramble, output logic g_err, output logic [31:0] g_rd);
        int n;
        bit busy_ok;
        bit seen;
        req_v[k] = 1'b1;
        we_v[k]  = w;
        a_v[k]   = addr;
        wd_v[k]  = data;
        @(posedge clk);
        n = 0;
        busy_ok = 1'b1;
        seen = 1'b0;
        g_err = 1'b0;
        g_rd = 32'd0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_v[k] = 1'b0;
                if (scramble) begin
                    we_v[k] = ~w;
                    a_v[k]  = $urandom();
                    wd_v[k] = $urandom();
                end
            end
            if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
            if (ready_v[k] === 1'b1) begin
                seen  = 1'b1;
                g_err = err_v[k];
                g_rd  = rd_v[k];
            end
        end
        chk("latency", k, 32'(n), 32'(lat_of(k) + 1));
        chk("busy_hold", k, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        chk("idle_after", k, {30'd0, ready_v[k], busy_v[k]}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_err;
        logic [31:0] g_rd;
        logic        e_err;
        logic [31:0] e_rd;
        bit          no_ready;

        tbl[0]  = '{1'b1, 32'h000, 32'hA5A50000, 1'b0, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b1, 32'h100, 32'h0BADF00D, 1'b1, 1'b0, 32'h00000000};
        tbl[2]  = '{1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000};
        tbl[3]  = '{1'b0, 32'h010, 32'h00000000, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h013, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
        tbl[5]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000};
        tbl[6]  = '{1'b0, 32'h100, 32'h00000000, 1'b1, 1'b0, 32'h0BADF00D};
        tbl[7]  = '{1'b0, 32'h000, 32'h00000000, 1'b0, 1'b0, 32'hA5A50000};
        tbl[8]  = '{1'b1, 32'h3FC, 32'h12345678, 1'b0, 1'b0, 32'hA5A50000};
        tbl[9]  = '{1'b0, 32'h3FC, 32'h00000000, 1'b1, 1'b0, 32'h12345678};
        tbl[10] = '{1'b0, 32'h3FD, 32'h00000000, 1'b0, 1'b1, 32'h00000000};
        tbl[11] = '{1'b1, 32'h020, 32'h11111111, 1'b0, 1'b0, 32'h00000000};
        tbl[12] = '{1'b0, 32'h020, 32'h00000000, 1'b0, 1'b0, 32'h11111111};

        reset = 1'b0;
        req_v = 3'b000;
        we_v  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            a_v[i]    = 32'd0;
            wd_v[i]   = 32'd0;
            mdl_rd[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_flags", k, {29'd0, ready_v[k], err_v[k], busy_v[k]}, 32'd0);
            chk("reset_rd", k, rd_v[k], 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Directed vectors on the LATENCY=2 instance.
        for (int i = 0; i < 13; i++) begin
            do_txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].scr, g_err, g_rd);
            model(0, tbl[i].w, tbl[i].a, tbl[i].d, e_err, e_rd);
            chk($sformatf("tbl%0d_err", i), 0, {31'd0, g_err}, {31'd0, tbl[i].e});
            chk($sformatf("tbl%0d_rd", i), 0, g_rd, tbl[i].rd);
        end

        // Reset during WAIT of a write to 0x20 aborts it.
        req_v[0] = 1'b1;
        we_v[0]  = 1'b1;
        a_v[0]   = 32'h20;
        wd_v[0]  = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        chk("abort_busy", 0, {31'd0, busy_v[0]}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_flags", 0, {29'd0, ready_v[0], err_v[0], busy_v[0]}, 32'd0);
        chk("abort_rd", 0, rd_v[0], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) mdl_rd[k] = 32'd0;
        no_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready_v[0] !== 1'b0) no_ready = 1'b0;
        end
        chk("abort_no_ready", 0, {31'd0, no_ready}, 32'd1);
        do_txn(0, 1'b0, 32'h20, 32'd0, 1'b0, g_err, g_rd);
        model(0, 1'b0, 32'h20, 32'd0, e_err, e_rd);
        chk("abort_readback", 0, g_rd, 32'h11111111);
        chk("abort_readback_err", 0, {31'd0, g_err}, 32'd0);

        // Fill words 0..15 on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int wi = 0; wi < 16; wi++) begin
                logic [31:0] d;
                d = $urandom();
                do_txn(k, 1'b1, 32'(wi * 4), d, 1'b0, g_err, g_rd);
                model(k, 1'b1, 32'(wi * 4), d, e_err, e_rd);
                chk("fill_err", k, {31'd0, g_err}, {31'd0, e_err});
                chk("fill_rd", k, g_rd, e_rd);
            end
        end

        // LATENCY=0 with req held high: acceptances every 2 cycles, none during RESP.
        req_v[1] = 1'b1;
        we_v[1]  = 1'b0;
        a_v[1]   = 32'h0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            chk($sformatf("hold_ready%0d", n), 1, {31'd0, ready_v[1]}, 32'(n % 2));
            chk($sformatf("hold_busy%0d", n), 1, {31'd0, busy_v[1]}, 32'(n % 2));
            if (n % 2 == 1) chk("hold_rd", 1, rd_v[1], mdl_mem[1][0]);
        end
        req_v[1] = 1'b0;
        mdl_rd[1] = mdl_mem[1][0];

        // Random traffic against the reference model.
        for (int k = 0; k < 3; k++) begin
            int cnt;
            cnt = (k == 2) ? 12 : 40;
            for (int t = 0; t < cnt; t++) begin
                logic        w;
                logic [31:0] addr;
                logic [31:0] d;
                int          r;
                w = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 9);
                if (r < 8) addr = 32'($urandom_range(0, 15)) << 2;
                else if (r == 8) addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                else addr = ($urandom() | 32'h0000_0400) & 32'hFFFF_FFFC;
                d = $urandom();
                do_txn(k, w, addr, d, 1'($urandom_range(0, 1)), g_err, g_rd);
                model(k, w, addr, d, e_err, e_rd);
                chk("rand_err", k, {31'd0, g_err}, {31'd0, e_err});
                chk("rand_rd", k, g_rd, e_rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_mem_responder.md
Name: ucsbece154a_mem_responder

Overview:
Memory-side responder for the multicycle core's unified instruction/data memory port. It accepts word read/write requests from the controller/datapath side through a req/ready handshake. Each request is serviced after a programmable number of wait states, and completion is signalled with a one-cycle ready pulse carrying read data or an error flag. It sits between the core's Adr/WriteData/MemWrite path and an internal word-addressed storage array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the storage array (power of two, 4..65536)
LATENCY, 2, wait-state cycles between request acceptance and response (0..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req_i  input  1  request valid; sampled only in IDLE
we_i  input  1  1 = write, 0 = read; captured with request
a_i  input  32  byte address; captured with request
wd_i  input  32  write data; captured with request
rd_o  output  32  read data; valid when ready_o=1 and err_o=0; holds until the next response
ready_o  output  1  one-cycle completion pulse
err_o  output  1  error flag, valid only with ready_o
busy_o  output  1  high from the cycle after acceptance through the RESP cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - State forced to IDLE; wait counter cleared.
  - rd_o=0, ready_o=0, err_o=0, busy_o=0.
  - Storage contents are not cleared. Power-up contents are undefined.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req_i=1 at a clock edge: capture we_i, a_i, wd_i into internal registers and load the counter with LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
  - If req_i=0: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - Go to RESP on the edge where the counter reaches 0. Accept-to-ready latency is LATENCY+1 cycles.
  - req_i, we_i, a_i and wd_i are ignored. Deasserting req_i does not cancel the transaction.
- RESP (exactly one cycle): ready_o=1, then return to IDLE.
  - Error check: err_o=1 if captured a[1:0]!=0 (misaligned) or captured a[31:2] >= DEPTH_WORDS (out of range).
  - Read without error: rd_o = mem[a[31:2]].
  - Write without error: mem[a[31:2]] = wd on the RESP edge; rd_o keeps its previous value.
  - Any error: no storage update and rd_o=0.
- Back-to-back:
  - req_i high during RESP is not accepted.
  - The earliest next acceptance is the IDLE cycle after RESP, so minimum request spacing is LATENCY+2 cycles.
- Outputs ready_o, err_o, rd_o and busy_o are registered; no combinational path from inputs.
- Read-after-write to the same address in consecutive transactions returns the newly written data.
- Reset asserted in WAIT or RESP:
  - The transaction is aborted, no write occurs, and no ready pulse is issued.
  - After reset deasserts, the responder is in IDLE and accepts a new request on the next edge with req_i=1.
- Counter width is 4 bits. LATENCY=15 must not wrap or alias to 0.

Test Plan:
- LATENCY=2: write a=0x10, wd=0xDEADBEEF, then read a=0x10 → each ready_o pulses exactly 3 cycles after acceptance; read gives rd_o=0xDEADBEEF, err_o=0.
- Misaligned read a=0x13 and out-of-range write a=0x400 (DEPTH_WORDS=256) → ready_o with err_o=1, rd_o=0; a subsequent read of word 0x100>>2 shows no corruption.
- LATENCY=0: read accepted → ready_o the very next cycle. req_i held continuously high → acceptances every 2 cycles, none during RESP.
- req_i dropped and a_i/wd_i changed during WAIT → the transaction completes with the originally captured address/data.
- reset pulled low during WAIT of a write to a=0x20 (old value 0x11111111) → no ready pulse; after release, reading 0x20 returns 0x11111111.
- LATENCY=15: the counter does not wrap → ready_o 16 cycles after acceptance, busy_o high for all 16 cycles.
